// File: rtl/spi_mram_responder.sv
// rtl/spi_mram_responder.sv - SPI mode-0 slave model of a serial MRAM with byte array
//
// Ports:
//   clk_i      system clock, all logic on its rising edge
//   rst_i      asynchronous active-low reset
//   spiCs_i    chip select, active low, asynchronous to clk_i
//   spiClk_i   SPI clock (mode 0), asynchronous to clk_i
//   spiMosi_i  serial data in, MSB first
//   spiMiso_o  serial data out, MSB first
//   wel_o      write-enable latch (status bit 1)
//   err_o      one-cycle pulse when an unsupported opcode completes

module spi_mram_responder #(
   parameter int MEM_BYTES  = 1024,
   parameter int ADDR_BYTES = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic spiCs_i,
   input  logic spiClk_i,
   input  logic spiMosi_i,
   output logic spiMiso_o,
   output logic wel_o,
   output logic err_o
);

   localparam int AW = $clog2(MEM_BYTES);

   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRDI  = 8'h04;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_WREN  = 8'h06;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_STAT, S_IGNORE
   } state_t;

   state_t state, state_nxt;

   // synchronizers and SCK edge detection
   logic cs_meta, cs_sync;
   logic sck_meta, sck_sync, sck_prev;
   logic mosi_meta, mosi_sync;
   logic sck_rise, sck_fall;

   // datapath
   logic [6:0]    shift_in;
   logic [2:0]    bit_cnt;
   logic [3:0]    addr_cnt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_inc;
   logic [AW-1:0] addr_nxt;
   logic          rd_flag;
   logic [7:0]    out_sr;
   logic [7:0]    rx_byte;
   logic [7:0]    status_byte;
   logic [7:0]    mem [MEM_BYTES];

   // decoded controls
   logic rx_en;
   logic byte_done;
   logic last_addr;
   logic wr_commit;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cs_meta   <= 1'b1;
         cs_sync   <= 1'b1;
         sck_meta  <= 1'b0;
         sck_sync  <= 1'b0;
         sck_prev  <= 1'b0;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         cs_meta   <= spiCs_i;
         cs_sync   <= cs_meta;
         sck_meta  <= spiClk_i;
         sck_sync  <= sck_meta;
         sck_prev  <= sck_sync;
         mosi_meta <= spiMosi_i;
         mosi_sync <= mosi_meta;
      end
   end

   assign sck_rise    = sck_sync & ~sck_prev;
   assign sck_fall    = ~sck_sync & sck_prev;
   assign rx_byte     = {shift_in, mosi_sync};
   assign status_byte = {6'b0, wel_o, 1'b0};
   assign ptr_inc     = ptr + AW'(1);
   // Address bytes are accumulated straight into the pointer; bits above
   // the array size fall off the top, which gives the aliasing for free.
   assign addr_nxt    = AW'({ptr, rx_byte});

   // state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic; CS high overrides everything, including a
   // simultaneous SCK rise, so a bit on that edge is dropped
   always_comb begin
      state_nxt = state;
      if (cs_sync) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: state_nxt = S_CMD;
            S_CMD: begin
               if (byte_done) begin
                  case (rx_byte)
                     OP_RDSR:            state_nxt = S_STAT;
                     OP_READ, OP_WRITE:  state_nxt = S_ADDR;
                     default:            state_nxt = S_IGNORE;
                  endcase
               end
            end
            S_ADDR: begin
               if (byte_done && last_addr) state_nxt = rd_flag ? S_RD : S_WR;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // output / control decode
   always_comb begin
      rx_en     = 1'b0;
      last_addr = 1'b0;
      case (state)
         S_CMD, S_ADDR, S_RD, S_WR, S_STAT: rx_en = 1'b1;
         default: rx_en = 1'b0;
      endcase
      if (state == S_ADDR && addr_cnt == 4'(ADDR_BYTES - 1)) last_addr = 1'b1;
      byte_done = rx_en && !cs_sync && sck_rise && (bit_cnt == 3'd7);
      wr_commit = byte_done && (state == S_WR) && wel_o;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         shift_in  <= '0;
         bit_cnt   <= '0;
         addr_cnt  <= '0;
         ptr       <= '0;
         rd_flag   <= 1'b0;
         out_sr    <= '0;
         spiMiso_o <= 1'b0;
         wel_o     <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         err_o <= 1'b0;
         if (state == S_IDLE) begin
            bit_cnt   <= '0;
            addr_cnt  <= '0;
            out_sr    <= '0;
            spiMiso_o <= 1'b0;
         end else begin
            if (rx_en && !cs_sync && sck_rise) begin
               shift_in <= rx_byte[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
            end

            // the next outgoing byte is loaded on the 8th rising edge so its
            // MSB appears on the following falling edge
            if (byte_done) begin
               case (state)
                  S_CMD: begin
                     case (rx_byte)
                        OP_WREN:  wel_o   <= 1'b1;
                        OP_WRDI:  wel_o   <= 1'b0;
                        OP_RDSR:  out_sr  <= status_byte;
                        OP_READ:  rd_flag <= 1'b1;
                        OP_WRITE: rd_flag <= 1'b0;
                        default:  err_o   <= 1'b1;
                     endcase
                  end
                  S_ADDR: begin
                     ptr      <= addr_nxt;
                     addr_cnt <= addr_cnt + 4'd1;
                     if (last_addr && rd_flag) out_sr <= mem[addr_nxt];
                  end
                  S_RD: begin
                     ptr    <= ptr_inc;
                     out_sr <= mem[ptr_inc];
                  end
                  S_WR:   ptr    <= ptr_inc;
                  S_STAT: out_sr <= status_byte;
                  default: ;
               endcase
            end

            if (state == S_IGNORE) begin
               spiMiso_o <= 1'b0;
            end else if (sck_fall) begin
               spiMiso_o <= out_sr[7];
               out_sr    <= {out_sr[6:0], 1'b0};
            end
         end
      end
   end

   // byte array is deliberately outside the reset domain
   always_ff @(posedge clk_i) begin
      if (wr_commit) mem[ptr] <= rx_byte;
   end

endmodule

// File: tb/tb_spi_mram_responder.sv
// tb/tb_spi_mram_responder.sv - self-checking bench for spi_mram_responder

module tb_spi_mram_responder;

   localparam int MEM = 1024;

   logic clk_i = 1'b0;
   logic rst_i;
   logic spiCs_i;
   logic spiClk_i;
   logic spiMosi_i;
   logic spiMiso_o;
   logic wel_o;
   logic err_o;

   spi_mram_responder #(.MEM_BYTES(MEM), .ADDR_BYTES(3)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .spiCs_i   (spiCs_i),
      .spiClk_i  (spiClk_i),
      .spiMosi_i (spiMosi_i),
      .spiMiso_o (spiMiso_o),
      .wel_o     (wel_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;
   int err_pulses = 0;

   // reference model: flat byte array plus the write-enable latch
   logic [7:0] m_mem [MEM];
   logic       m_wel;
   logic [7:0] wbuf [8];

   always @(posedge clk_i) if (err_o === 1'b1) err_pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic spi_begin();
      @(negedge clk_i);
      spiCs_i = 1'b0;
   endtask

   // shifts nbits MSB-first, sampling MISO just before each rising SCK
   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spiMosi_i = tx[i];
         repeat (5) @(negedge clk_i);
         rx[i] = spiMiso_o;
         spiClk_i = 1'b1;
         repeat (5) @(negedge clk_i);
         spiClk_i = 1'b0;
      end
   endtask

   task automatic spi_end();
      repeat (5) @(negedge clk_i);
      spiCs_i   = 1'b1;
      spiMosi_i = 1'b0;
      repeat (8) @(negedge clk_i);
   endtask

   task automatic send_addr(input int addr);
      logic [7:0] rx;
      spi_bits(8'((addr >> 16) & 255), 8, rx);
      spi_bits(8'((addr >> 8) & 255), 8, rx);
      spi_bits(8'(addr & 255), 8, rx);
   endtask

   task automatic cmd_only(input logic [7:0] op);
      logic [7:0] rx;
      spi_begin();
      spi_bits(op, 8, rx);
      spi_end();
      if (op == 8'h06) m_wel = 1'b1;
      if (op == 8'h04) m_wel = 1'b0;
   endtask

   task automatic do_rdsr(input string tag, input int n);
      logic [7:0] rx;
      spi_begin();
      spi_bits(8'h05, 8, rx);
      for (int i = 0; i < n; i++) begin
         spi_bits(8'h00, 8, rx);
         check(tag, {24'h0, rx}, {30'h0, m_wel, 1'b0});
      end
      spi_end();
      check({tag, "_wel"}, {31'h0, wel_o}, {31'h0, m_wel});
   endtask

   task automatic do_write(input int addr, input int n);
      logic [7:0] rx;
      spi_begin();
      spi_bits(8'h02, 8, rx);
      send_addr(addr);
      for (int i = 0; i < n; i++) begin
         spi_bits(wbuf[i], 8, rx);
         if (m_wel) m_mem[(addr + i) % MEM] = wbuf[i];
      end
      spi_end();
   endtask

   task automatic do_read(input string tag, input int addr, input int n);
      logic [7:0] rx;
      spi_begin();
      spi_bits(8'h03, 8, rx);
      send_addr(addr);
      for (int i = 0; i < n; i++) begin
         spi_bits(8'h00, 8, rx);
         check(tag, {24'h0, rx}, {24'h0, m_mem[(addr + i) % MEM]});
      end
      spi_end();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rx;
      int addr, n, op;

      for (int i = 0; i < MEM; i++) m_mem[i] = 8'h00;
      m_wel     = 1'b0;
      rst_i     = 1'b0;
      spiCs_i   = 1'b1;
      spiClk_i  = 1'b0;
      spiMosi_i = 1'b0;
      repeat (4) @(negedge clk_i);
      check("rst_miso", {31'h0, spiMiso_o}, 32'h0);
      check("rst_wel",  {31'h0, wel_o},     32'h0);
      check("rst_err",  {31'h0, err_o},     32'h0);
      rst_i = 1'b1;
      repeat (4) @(negedge clk_i);

      do_rdsr("rdsr_idle", 2);
      cmd_only(8'h06);
      do_rdsr("rdsr_wren", 3);

      wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
      do_write(32'h10, 2);
      do_read("rd_10", 32'h10, 2);
      check("rd_10_const", {24'h0, m_mem[16]}, 32'hA5);

      cmd_only(8'h04);
      wbuf[0] = 8'hFF;
      do_write(32'h20, 1);
      do_read("rd_20_wrdi", 32'h20, 1);
      check("wel_after_wrdi", {31'h0, wel_o}, 32'h0);

      cmd_only(8'h06);
      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      do_write(MEM - 1, 2);
      do_read("rd_wrap", 32'h0, 1);
      do_read("rd_alias", 32'h400, 1);
      do_read("rd_top", MEM - 1, 2);

      // unsupported opcode: single err pulse, MISO quiet
      check("err_before", err_pulses, 0);
      spi_begin();
      spi_bits(8'h9F, 8, rx);
      check("bad_op_miso0", {24'h0, rx}, 32'h0);
      spi_bits(8'hFF, 8, rx);
      check("bad_op_miso1", {24'h0, rx}, 32'h0);
      spi_end();
      check("err_pulses", err_pulses, 1);
      do_read("rd_after_err", 32'h10, 2);

      // partial write byte is discarded
      spi_begin();
      spi_bits(8'h02, 8, rx);
      send_addr(32'h30);
      spi_bits(8'hC3, 4, rx);
      spi_end();
      do_read("rd_partial", 32'h30, 1);

      // reset in the middle of a READ
      spi_begin();
      spi_bits(8'h03, 8, rx);
      send_addr(32'h10);
      repeat (5) @(negedge clk_i);
      check("mid_rd_msb", {31'h0, spiMiso_o}, {31'h0, m_mem[16][7]});
      rst_i     = 1'b0;
      spiCs_i   = 1'b1;
      spiMosi_i = 1'b0;
      #1;
      check("rst_mid_miso", {31'h0, spiMiso_o}, 32'h0);
      check("rst_mid_wel",  {31'h0, wel_o},     32'h0);
      m_wel = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (4) @(negedge clk_i);
      do_read("rd_after_rst", 32'h10, 2);
      do_rdsr("rdsr_after_rst", 1);

      // randomized traffic against the model
      for (int t = 0; t < 24; t++) begin
         op   = $urandom_range(0, 4);
         addr = int'($urandom & 32'h00FF_FFFF);
         n    = $urandom_range(1, 4);
         case (op)
            0: cmd_only(8'h06);
            1: cmd_only(8'h04);
            2, 3: begin
               for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
               if ($urandom_range(0, 3) != 0) cmd_only(8'h06);
               do_write(addr, n);
               do_read("rnd_rdback", addr, n);
            end
            default: do_read("rnd_rd", addr, n);
         endcase
      end
      do_rdsr("rdsr_final", 1);
      check("err_final", err_pulses, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_mram_responder.md
# spi_mram_responder

Synthesizable SPI-slave model of a serial MRAM device, the far end of the wishbone-to-SPI `mram` controller. It oversamples the SPI pins on the system clock and decodes a mode-0 opcode/address/data stream. It serves byte reads and writes from an internal byte array. Used as the device-side counterpart in controller benches and as an on-chip scratch memory behind an SPI link.

## Interface

Parameters:
- `MEM_BYTES`, default 1024: size of the byte array; power of two.
- `ADDR_BYTES`, default 3: number of address bytes following READ/WRITE opcodes.

Ports:
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `spiCs_i`  in  1  chip select, active low; asynchronous to `clk_i`.
- `spiClk_i`  in  1  SPI clock, mode 0; asynchronous.
- `spiMosi_i`  in  1  serial data in, MSB first.
- `spiMiso_o`  out  1  serial data out, MSB first.
- `wel_o`  out  1  write-enable latch (status bit 1).
- `err_o`  out  1  one-cycle pulse when an unsupported opcode completes.

## Operation

- Inputs `spiCs_i`, `spiClk_i` and `spiMosi_i` each pass through 2-FF synchronizers.
- SCK edges are detected on the synchronized signal.
- MOSI is sampled on the detected rising SCK edge.
- MISO is updated on the detected falling SCK edge.
- Bits are shifted MSB first into an 8-bit shift register, with a 3-bit bit counter.
- State machine states: IDLE, CMD, ADDR, RD, WR, STAT, IGNORE.
- IDLE: entered when synchronized CS is high. Clears the bit counter and address byte count; `spiMiso_o`=0. Moves to CMD when synchronized CS falls.
- CMD: after 8 bits, dispatch on the opcode:
  - 0x06 WREN: set WEL; go to IGNORE.
  - 0x04 WRDI: clear WEL; go to IGNORE.
  - 0x05 RDSR: go to STAT; load the status byte {6'b0, WEL, 1'b0}.
  - 0x03 READ: go to ADDR, read flag set.
  - 0x02 WRITE: go to ADDR, write flag set.
  - Any other opcode: pulse `err_o` for 1 cycle; go to IGNORE.
- ADDR: collect `ADDR_BYTES` bytes, MSB first, into an address register. Only the low log2(`MEM_BYTES`) bits are used; upper bits are ignored. After the last byte:
  - READ: go to RD and load mem[addr] into the output shift register.
  - WRITE: go to WR.
- RD: each completed byte increments the address and loads the next byte. The address wraps from `MEM_BYTES`-1 to 0.
- WR: each completed byte writes mem[addr] when WEL=1, otherwise it is discarded; then the address increments with the same wrap. A partial byte at CS deassertion is discarded.
- STAT: the status byte repeats for as long as CS stays low.
- IGNORE: MOSI is ignored and MISO=0 until CS rises.
- WEL is changed only by WREN, WRDI and reset; a WRITE does not clear it.
- CS rising in any state returns to IDLE next cycle and aborts any transfer. Memory and WEL are kept.
- The byte array is not cleared by reset; it reads as 0 at simulation time 0.

## Timing

- Reset values: `spiMiso_o`=0, `wel_o`=0, `err_o`=0, state=IDLE, synchronizers=CS high / SCK low / MOSI 0.
- Synchronizer latency: 2 `clk_i` cycles; edge detect adds 1 cycle.
- Constraints on the master:
  - SCK high and low phases each ≥4 `clk_i` cycles.
  - CS fall to first SCK rise ≥4 cycles.
  - Last SCK fall to CS rise ≥4 cycles.
- MISO changes within 4 `clk_i` cycles after an SCK fall. It is stable before the next SCK rise under the constraints above.
- The first read-data MSB is driven at the SCK fall following the last address bit. The first status MSB is driven at the SCK fall after opcode bit 0.
- A memory write commits 1 cycle after the 8th rising edge of the data byte is detected.
- `err_o` is asserted 1 cycle after the 8th opcode bit is detected.
- If a rising edge and a CS rise are detected in the same cycle, CS wins and the bit is dropped.
- An asynchronous reset mid-transfer forces IDLE immediately. WEL is cleared; memory is untouched.

## Test plan

- Reset, then RDSR (0x05): returns 0x00 and `wel_o`=0. Then WREN (0x06) followed by RDSR returns 0x02 and `wel_o`=1.
- WREN, then WRITE addr 0x000010 with data 0xA5 0x5A, then READ addr 0x000010 for 2 bytes: MISO returns 0xA5, 0x5A.
- WRDI, then WRITE 0x000020 with data 0xFF, then READ 0x000020: returns the prior value 0x00.
- WREN, then WRITE at address `MEM_BYTES`-1 with data 0x11 0x22: a READ at 0x000000 returns 0x22. Address bits above the array size are ignored, so address 0x000400 aliases 0x000000.
- Opcode 0x9F: `err_o` pulses exactly 1 cycle; MISO stays 0; a subsequent READ works normally.
- CS raised after 4 data bits of a WRITE: the byte is not written. Reset asserted mid-READ: `spiMiso_o`=0 and `wel_o`=0 immediately, and memory is preserved on the next READ.
